// File: rtl/rgb2gray_frame_ctrl_if.sv
// Memory-read, converter and gray-buffer signals shared by the frame controller and its neighbours.
// master = the frame controller, slave = memories / RGB2GRAY / gray buffer side.
interface rgb2gray_frame_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] r_in;
    logic [DATA_W-1:0] g_in;
    logic [DATA_W-1:0] b_in;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] g_out;
    logic [DATA_W-1:0] b_out;
    logic              conv_we;
    logic [DATA_W-1:0] gray_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output rd_en, rd_addr, r_out, g_out, b_out, conv_we, wr_en, wr_addr, wr_data,
        input  r_in, g_in, b_in, gray_in, wr_ready
    );

    modport slave (
        input  rd_en, rd_addr, r_out, g_out, b_out, conv_we, wr_en, wr_addr, wr_data,
        output r_in, g_in, b_in, gray_in, wr_ready
    );
endinterface

// File: rtl/rgb2gray_frame_ctrl.sv
// Frame sequencer: reads PIX_CNT pixels, feeds RGB2GRAY, writes gray words in address order.
// Optional macro FRAME_CNT_EN adds an 8-bit completed-frame counter output o_frame_num.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for i_start, not busy
// S_RUN   | issuing reads, one per cycle while the gray buffer is ready
// S_DRAIN | all reads issued, waiting for the final gray write
// S_DONE  | one-cycle done pulse, then back to idle
module rgb2gray_frame_ctrl #(
    parameter int PIX_CNT  = 40000,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int CONV_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
`ifdef FRAME_CNT_EN
    output logic [7:0] o_frame_num,
`endif
    rgb2gray_frame_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    // r_vld[0] marks memory data at the converter, r_vld[CONV_LAT] marks a valid gray word
    logic [CONV_LAT:0] r_vld;
    logic              w_rd_en;
    logic              w_wr_en;
    logic              w_conv_we;
    logic              w_busy;
    logic              w_done;
    logic              w_ready;
    logic [DATA_W-1:0] w_r_pix;
    logic [DATA_W-1:0] w_g_pix;
    logic [DATA_W-1:0] w_b_pix;
    logic [DATA_W-1:0] w_gray;

    assign w_ready   = bus.wr_ready;
    assign w_conv_we = r_vld[0] & w_ready;
    assign w_wr_en   = r_vld[CONV_LAT] & w_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy  = 1'b1;
                w_rd_en = w_ready;
                if (w_rd_en && (r_rd_addr == LAST_ADDR)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_wr_en && (r_wr_addr == LAST_ADDR)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters saturate at the last address so they never leave the frame
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_addr <= '0;
            r_wr_addr <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_rd_addr <= '0;
            r_wr_addr <= '0;
        end else begin
            if (w_rd_en && (r_rd_addr != LAST_ADDR)) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
            if (w_wr_en && (r_wr_addr != LAST_ADDR)) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    // The whole chain freezes on a stall so read data and gray words stay aligned
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else if (w_ready) begin
            r_vld <= {r_vld[CONV_LAT-1:0], w_rd_en};
        end
    end

`ifdef FRAME_CNT_EN
    logic [7:0] r_frame_num;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_num <= '0;
        end else if (r_state == S_DONE) begin
            r_frame_num <= r_frame_num + 8'd1;
        end
    end

    assign o_frame_num = r_frame_num;
`endif

    assign w_r_pix = bus.r_in;
    assign w_g_pix = bus.g_in;
    assign w_b_pix = bus.b_in;
    assign w_gray  = bus.gray_in;

    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.r_out   = w_r_pix;
    assign bus.g_out   = w_g_pix;
    assign bus.b_out   = w_b_pix;
    assign bus.conv_we = w_conv_we;
    assign bus.wr_en   = w_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = w_gray;

    assign o_busy = w_busy;
    assign o_done = w_done;

endmodule

// File: tb/tb_rgb2gray_frame_ctrl.sv
// Bench for rgb2gray_frame_ctrl: two instances (8 px / latency 1 and 1 px / latency 3),
// random pixel data and stalls, checked against an in-order expected-write model.
module tb_rgb2gray_frame_ctrl;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int PIX_A = 8;
    localparam int LAT_A = 1;
    localparam int PIX_B = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst     = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic rdy     = 1'b1;
    logic busy_a, done_a, busy_b, done_b;
`ifdef FRAME_CNT_EN
    logic [7:0] fn_a, fn_b;
`endif

    rgb2gray_frame_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    rgb2gray_frame_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    rgb2gray_frame_ctrl #(.PIX_CNT(PIX_A), .ADDR_W(AW), .DATA_W(DW), .CONV_LAT(LAT_A)) u_dut_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start_a),
        .o_busy      (busy_a),
        .o_done      (done_a),
`ifdef FRAME_CNT_EN
        .o_frame_num (fn_a),
`endif
        .bus         (ifa)
    );

    rgb2gray_frame_ctrl #(.PIX_CNT(PIX_B), .ADDR_W(AW), .DATA_W(DW), .CONV_LAT(LAT_B)) u_dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start_b),
        .o_busy      (busy_b),
        .o_done      (done_b),
`ifdef FRAME_CNT_EN
        .o_frame_num (fn_b),
`endif
        .bus         (ifb)
    );

    assign ifa.wr_ready = rdy;
    assign ifb.wr_ready = rdy;

    logic [DW-1:0] mr [0:7];
    logic [DW-1:0] mg [0:7];
    logic [DW-1:0] mb [0:7];

    function automatic logic [DW-1:0] gray_f(input logic [DW-1:0] r, input logic [DW-1:0] g,
                                             input logic [DW-1:0] b);
        return (r * 77 + g * 150 + b * 29) >> 8;
    endfunction

    // Source memories: data one cycle after a read, held otherwise
    always @(posedge clk) begin
        if (ifa.rd_en) begin
            ifa.r_in <= mr[ifa.rd_addr[2:0]];
            ifa.g_in <= mg[ifa.rd_addr[2:0]];
            ifa.b_in <= mb[ifa.rd_addr[2:0]];
        end
        if (ifb.rd_en) begin
            ifb.r_in <= mr[ifb.rd_addr[2:0]];
            ifb.g_in <= mg[ifb.rd_addr[2:0]];
            ifb.b_in <= mb[ifb.rd_addr[2:0]];
        end
    end

    // Converter models: a word only becomes real gray when taken under CONV_WE
    logic [DW-1:0] cva [0:LAT_A-1];
    logic [DW-1:0] cvb [0:LAT_B-1];

    always @(posedge clk) begin
        if (ifa.wr_ready) begin
            cva[0] <= ifa.conv_we ? gray_f(ifa.r_out, ifa.g_out, ifa.b_out) : 32'hDEAD_BEEF;
            for (int i = 1; i < LAT_A; i++) cva[i] <= cva[i-1];
        end
        if (ifb.wr_ready) begin
            cvb[0] <= ifb.conv_we ? gray_f(ifb.r_out, ifb.g_out, ifb.b_out) : 32'hDEAD_BEEF;
            for (int i = 1; i < LAT_B; i++) cvb[i] <= cvb[i-1];
        end
    end

    assign ifa.gray_in = cva[LAT_A-1];
    assign ifb.gray_in = cvb[LAT_B-1];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    int rd_a, wr_a, first_rd_a, last_rd_a, first_wr_a, last_wr_a, done_cnt_a, done_cyc_a;
    int rd_b, wr_b, rd_cyc_b, wr_cyc_b, done_cnt_b, done_cyc_b;
    int frames_a = 0;
    int frames_b = 0;
    bit fn_armed = 0;

    // One clock: inputs just after the edge, outputs checked at the falling edge
    task automatic step(input bit st_a, input bit st_b, input bit ready, input bit reset);
        @(posedge clk);
        #1;
        start_a = st_a;
        start_b = st_b;
        rdy     = ready;
        rst     = reset;
        @(negedge clk);
        cyc++;
`ifdef FRAME_CNT_EN
        if (fn_armed) begin
            check_val("frame_num_a", fn_a, frames_a % 256);
            check_val("frame_num_b", fn_b, frames_b % 256);
        end
`endif
        if (ifa.rd_en) begin
            check_val("rd_addr_a", ifa.rd_addr, rd_a);
            if (rd_a == 0) first_rd_a = cyc;
            last_rd_a = cyc;
            rd_a++;
        end
        if (ifa.wr_en) begin
            check_val("wr_addr_a", ifa.wr_addr, wr_a);
            if (wr_a < PIX_A)
                check_val("wr_data_a", ifa.wr_data, gray_f(mr[wr_a], mg[wr_a], mb[wr_a]));
            if (wr_a == 0) first_wr_a = cyc;
            last_wr_a = cyc;
            wr_a++;
        end
        if (!ready) check_val("stall_quiet_a", {ifa.rd_en, ifa.conv_we, ifa.wr_en}, 0);
        if (done_a) begin
            check_val("busy_at_done_a", busy_a, 1);
            done_cnt_a++;
            done_cyc_a = cyc;
            frames_a++;
        end
        if (ifb.rd_en) begin
            check_val("rd_addr_b", ifb.rd_addr, 0);
            rd_cyc_b = cyc;
            rd_b++;
        end
        if (ifb.wr_en) begin
            check_val("wr_addr_b", ifb.wr_addr, 0);
            check_val("wr_data_b", ifb.wr_data, gray_f(mr[0], mg[0], mb[0]));
            wr_cyc_b = cyc;
            wr_b++;
        end
        if (done_b) begin
            done_cnt_b++;
            done_cyc_b = cyc;
            frames_b++;
        end
        if (reset) begin
            frames_a = 0;
            frames_b = 0;
            fn_armed = 1;
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 8; i++) begin
            mr[i] = $urandom_range(0, 255);
            mg[i] = $urandom_range(0, 255);
            mb[i] = $urandom_range(0, 255);
        end
    endtask

    // stall_wr < 0: no fixed stall; exp_done < 0: skip cycle-exact timing checks
    task automatic frame_a(input int stall_wr, input int stall_len, input bit poke,
                           input int rnd_pct, input int exp_done);
        int  stall_left = 0;
        bit  stall_used = 0;
        int  n = 0;
        int  t0;
        bit  r_n;
        bit  s_n;
        fill_mem();
        rd_a = 0; wr_a = 0; done_cnt_a = 0;
        first_rd_a = -1; first_wr_a = -1; last_rd_a = -1; last_wr_a = -1; done_cyc_a = -1;
        step(1, 0, 1, 0);
        t0 = cyc;
        while (done_cnt_a == 0 && n < 200) begin
            r_n = 1;
            if (!stall_used && stall_wr >= 0 && wr_a >= stall_wr) begin
                stall_used = 1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                r_n = 0;
                stall_left--;
            end else if (rnd_pct > 0 && $urandom_range(0, 99) < rnd_pct) begin
                r_n = 0;
            end
            s_n = poke && (wr_a == PIX_A || $urandom_range(0, 2) == 0);
            step(s_n, 0, r_n, 0);
            n++;
        end
        check_val("frame_timeout_a", n >= 200, 0);
        check_val("rd_count_a", rd_a, PIX_A);
        check_val("wr_count_a", wr_a, PIX_A);
        check_val("done_pulses_a", done_cnt_a, 1);
        check_val("done_after_last_wr_a", done_cyc_a - last_wr_a, 1);
        if (exp_done >= 0) begin
            check_val("done_time_a", done_cyc_a - t0, exp_done);
            check_val("issue_to_write_a", first_wr_a - first_rd_a, 1 + LAT_A);
            if (stall_len == 0) begin
                check_val("rd_burst_a", last_rd_a - first_rd_a, PIX_A - 1);
                check_val("wr_burst_a", last_wr_a - first_wr_a, PIX_A - 1);
            end
        end
        step(0, 0, 1, 0);
        check_val("busy_after_done_a", busy_a, 0);
        check_val("done_width_a", done_a, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check_val("no_restart_a", rd_a, PIX_A);
    endtask

    task automatic frame_b();
        int n = 0;
        int t0;
        fill_mem();
        rd_b = 0; wr_b = 0; done_cnt_b = 0; rd_cyc_b = -1; wr_cyc_b = -1; done_cyc_b = -1;
        step(0, 1, 1, 0);
        t0 = cyc;
        while (done_cnt_b == 0 && n < 50) begin
            step(0, 0, 1, 0);
            n++;
        end
        check_val("frame_timeout_b", n >= 50, 0);
        check_val("rd_count_b", rd_b, PIX_B);
        check_val("wr_count_b", wr_b, PIX_B);
        check_val("rd_time_b", rd_cyc_b - t0, 1);
        check_val("issue_to_write_b", wr_cyc_b - rd_cyc_b, 1 + LAT_B);
        check_val("done_after_wr_b", done_cyc_b - wr_cyc_b, 1);
        step(0, 0, 1, 0);
        check_val("busy_after_done_b", busy_b, 0);
    endtask

    initial begin
        int n;
        fill_mem();
        repeat (3) step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        check_val("rst_busy_a", busy_a, 0);
        check_val("rst_done_a", done_a, 0);
        check_val("rst_strobes_a", {ifa.rd_en, ifa.conv_we, ifa.wr_en}, 0);
        check_val("rst_rd_addr_a", ifa.rd_addr, 0);
        check_val("rst_wr_addr_a", ifa.wr_addr, 0);
        check_val("rst_busy_b", busy_b, 0);
        check_val("rst_strobes_b", {ifb.rd_en, ifb.conv_we, ifb.wr_en}, 0);

        frame_a(-1, 0, 0, 0, 11);
        frame_a(3, 3, 0, 0, 14);
        frame_a(-1, 0, 1, 0, 11);
        frame_a(-1, 0, 0, 0, 11);

        // Abort a frame with reset at the fifth write
        fill_mem();
        rd_a = 0; wr_a = 0; done_cnt_a = 0;
        step(1, 0, 1, 0);
        n = 0;
        while (wr_a < 4 && n < 50) begin
            step(0, 0, 1, 0);
            n++;
        end
        check_val("abort_timeout_a", n >= 50, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        check_val("post_rst_wr_en_a", ifa.wr_en, 0);
        check_val("post_rst_busy_a", busy_a, 0);
        check_val("post_rst_rd_addr_a", ifa.rd_addr, 0);
        check_val("post_rst_rd_en_a", ifa.rd_en, 0);
        frame_a(-1, 0, 0, 0, 11);

        frame_b();
        frame_b();

        repeat (4) frame_a(-1, 0, 1, 30, -1);
        repeat (3) frame_a($urandom_range(0, 7), $urandom_range(1, 4), 1, 0, -1);

`ifdef FRAME_CNT_EN
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        repeat (52) frame_a(-1, 0, 0, 0, 11);
        check_val("frame_num_52", fn_a, 52);
        repeat (204) frame_a(-1, 0, 0, 0, 11);
        check_val("frame_num_wrap", fn_a, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb2gray_frame_ctrl.md
Name: rgb2gray_frame_ctrl

Overview:
Frame sequencer for the RGB2GRAY converter. On START it walks PIX_CNT pixel addresses through the R/G/B source memories, presents each pixel to RGB2GRAY with WE, and writes the resulting GRAY word to the gray output buffer at the matching address. It sits between the per-frame pixel memories and the output buffer and runs one frame per START, replacing the bench-driven pixel loop.

Parameters:
PIX_CNT, 40000, pixels per frame (200x200); legal range 1..2^ADDR_W-1
ADDR_W, 16, width of read/write address counters
DATA_W, 32, pixel and gray word width
CONV_LAT, 1, RGB2GRAY cycles from WE-qualified input to valid GRAY (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
START  in  1  one-cycle pulse; begins a frame when idle
BUSY  out  1  high from the cycle after an accepted START until DONE
DONE  out  1  one-cycle pulse after the last gray write
RD_EN  out  1  source memory read enable
RD_ADDR  out  ADDR_W  source memory address (shared by R/G/B)
R_IN, G_IN, B_IN  in  DATA_W each  memory read data, valid 1 cycle after RD_EN; memory holds data while RD_EN=0
R_OUT, G_OUT, B_OUT  out  DATA_W each  to RGB2GRAY R/G/B; combinational pass-through of R_IN/G_IN/B_IN
CONV_WE  out  1  to RGB2GRAY WE
GRAY_IN  in  DATA_W  from RGB2GRAY GRAY
WR_EN  out  1  gray buffer write strobe
WR_ADDR  out  ADDR_W  gray buffer address
WR_DATA  out  DATA_W  = GRAY_IN (pass-through)
WR_READY  in  1  gray buffer can accept a write; 0 = stall

Behaviour:
- Reset (RST=1 at edge, any state, including mid-frame): state IDLE; BUSY, DONE, RD_EN, CONV_WE, WR_EN = 0; RD_ADDR, WR_ADDR, all pipeline valid bits = 0. No write in the cycle after reset.
- Pipeline: valid chain v0 (read issued) -> v1 (memory data at converter, CONV_WE = v1 & WR_READY) -> CONV_LAT further stages -> vlast (WR_EN = vlast & WR_READY). Issue-to-write latency = 1+CONV_LAT cycles with no stall.
- Stall: WR_READY=0 forces RD_EN, CONV_WE, WR_EN low that cycle; all valid bits, RD_ADDR, WR_ADDR hold. No pixel lost or duplicated.
- FSM states:
  IDLE: BUSY=0. START=1 -> RUN, RD_ADDR<=0, WR_ADDR<=0.
  RUN: BUSY=1. RD_EN = WR_READY; on each issue RD_ADDR++. Issue of address PIX_CNT-1 -> DRAIN (RD_ADDR holds at PIX_CNT-1).
  DRAIN: BUSY=1, RD_EN=0; when final write (WR_ADDR=PIX_CNT-1 with WR_EN) occurs -> DONE_ST.
  DONE_ST: DONE=1, BUSY=1 for one cycle -> IDLE.
- WR_ADDR increments after each WR_EN; write k always carries gray of read address k.
- START while not IDLE is ignored. START in same cycle as DONE_ST is ignored (must arrive in IDLE).
- PIX_CNT=1: RUN lasts one issue cycle, then DRAIN.
- Address width: counters never exceed PIX_CNT-1; no wrap within a frame.

Optional Feature:
FRAME_CNT_EN: when defined, adds output FRAME_NUM [7:0], reset 0, incremented in the DONE_ST cycle (visible the cycle after DONE), wraps 255->0; RST clears it. When undefined, port and counter are absent; all other behaviour identical.

Test Plan:
- PIX_CNT=8, CONV_LAT=1, WR_READY=1, START pulse -> RD_ADDR 0..7 on 8 consecutive cycles, WR_EN on 8 consecutive cycles starting 2 cycles after first RD_EN, WR_ADDR 0..7, DONE 1 cycle after write 7, BUSY low next.
- Same, WR_READY low for 3 cycles after the 3rd write -> exactly 8 writes, addresses 0..7 in order, WR_DATA per address matches gray model, DONE delayed 3 cycles.
- START pulsed again during RUN and in DONE_ST -> ignored; exactly one frame of 8 writes; fresh START in IDLE runs a second frame from address 0.
- RST asserted at write 4 -> next cycle WR_EN=0, BUSY=0, RD_ADDR=0; new START yields full 8-write frame from 0.
- PIX_CNT=1, CONV_LAT=3 -> one RD_EN at addr 0, one WR_EN 4 cycles later at addr 0, then DONE.
- FRAME_CNT_EN defined, 52 back-to-back frames -> FRAME_NUM=52 after last DONE; 256 frames -> FRAME_NUM wraps to 0.
